// File: rtl/gcd_binary.sv
// Binary (Stein) GCD unit with start/ready handshake; shift/subtract only.
// Optional busy-cycle counter on the cycles port when GCD_CYCLES_EN is defined.
module gcd_binary #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             ready,
  output logic [WIDTH-1:0] out
`ifdef GCD_CYCLES_EN
  ,
  output logic [15:0]      cycles
`endif
);
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CHECK, ODD, LOOP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [KW-1:0]    k_q, k_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    out_d   = out_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = ina;
          b_d     = inb;
          k_d     = '0;
          ready_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (a_q == '0) begin
          out_d   = b_q << k_q;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (b_q == '0) begin
          out_d   = a_q << k_q;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = ODD;
        end
      end
      ODD: begin
        if (!a_q[0]) a_d = a_q >> 1;
        else         state_d = LOOP;
      end
      LOOP: begin
        // a stays odd here, so b==0 means a holds the odd part of the gcd
        if (b_q == '0) begin
          out_d   = a_q << k_q;
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = b_q;
          b_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign out   = out_q;

`ifdef GCD_CYCLES_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (start) cyc_d = '0;
    end else if (cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_binary.sv
// Directed bench for gcd_binary: 8-bit vector table, handshake/abort sequences, 16-bit sweep.
module tb_gcd_binary;
  logic        clk = 1'b0;
  logic        nrst;
  logic        start8, start16;
  logic [7:0]  ina8, inb8, out8;
  logic [15:0] ina16, inb16, out16;
  logic        ready8, ready16;
`ifdef GCD_CYCLES_EN
  logic [15:0] cyc8, cyc16;
`endif

  always #5 clk = ~clk;

  gcd_binary #(.WIDTH(8)) u_dut8 (
    .clk(clk), .nrst(nrst), .start(start8), .ina(ina8), .inb(inb8),
    .ready(ready8), .out(out8)
`ifdef GCD_CYCLES_EN
    , .cycles(cyc8)
`endif
  );

  gcd_binary #(.WIDTH(16)) u_dut16 (
    .clk(clk), .nrst(nrst), .start(start16), .ina(ina16), .inb(inb16),
    .ready(ready16), .out(out16)
`ifdef GCD_CYCLES_EN
    , .cycles(cyc16)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    int         busy;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Issue one start pulse, count ready-low cycles at negedges, return out.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output int busy);
    logic [15:0] prev;
    bit          done;
    @(negedge clk);
    prev = w16 ? out16 : {8'h00, out8};
    if (w16) begin ina16 = a; inb16 = b; start16 = 1'b1; end
    else begin ina8 = a[7:0]; inb8 = b[7:0]; start8 = 1'b1; end
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (w16 ? ready16 : ready8) done = 1'b1;
      else begin
        busy++;
        if (busy == 1) chk("hold_out", w16 ? out16 : {8'h00, out8}, prev);
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: ready still 0 after 300 cycles, expected 1");
    end
    res = w16 ? out16 : {8'h00, out8};
  endtask

  initial begin
    logic [15:0] res, ra, rb;
    int          busy;
    bit          seen;

    vecs[0] = '{8'd12,  8'd18,  8'd6,   8};
    vecs[1] = '{8'd0,   8'd0,   8'd0,   1};
    vecs[2] = '{8'd0,   8'd45,  8'd45,  1};
    vecs[3] = '{8'd200, 8'd0,   8'd200, 1};
    vecs[4] = '{8'd255, 8'd17,  8'd17,  10};
    vecs[5] = '{8'd240, 8'd36,  8'd12,  12};
    vecs[6] = '{8'd7,   8'd7,   8'd7,   4};
    vecs[7] = '{8'd128, 8'd64,  8'd64,  11};
    vecs[8] = '{8'd1,   8'd255, 8'd1,   18};

    nrst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    ina8 = '0; inb8 = '0; ina16 = '0; inb16 = '0;

    // asynchronous reset between edges
    #3 nrst = 1'b0;
    #1;
    chk("rst_ready8", ready8, 1);
    chk("rst_out8", out8, 0);
    chk("rst_ready16", ready16, 1);
    chk("rst_out16", out16, 0);
`ifdef GCD_CYCLES_EN
    chk("rst_cycles8", cyc8, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[i]) begin
      run_op(1'b0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, res, busy);
      chk($sformatf("vec%0d_out", i), res, vecs[i].g);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
`ifdef GCD_CYCLES_EN
      chk($sformatf("vec%0d_cycles", i), cyc8, vecs[i].busy);
`endif
    end

    // start held high through a (255,17) run; operands change mid-run
    @(negedge clk);
    ina8 = 8'd255; inb8 = 8'd17; start8 = 1'b1;
    @(negedge clk);
    ina8 = 8'd12; inb8 = 8'd18;
    busy = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (ready8) seen = 1'b1;
      else begin busy++; @(negedge clk); end
    end
    chk("ign_out", out8, 17);
    chk("ign_busy", busy, 10);
    @(negedge clk);
    chk("ign_reaccept", ready8, 0);
    start8 = 1'b0;
    busy = 1;
    seen = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (ready8) seen = 1'b1;
      else begin busy++; @(negedge clk); end
    end
    chk("ign_next_out", out8, 6);
    chk("ign_next_busy", busy, 8);

    // abort (240,36) at busy cycle 3
    @(negedge clk);
    ina8 = 8'd240; inb8 = 8'd36; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", ready8, 0);
    #2 nrst = 1'b0;
    #1;
    chk("abort_ready", ready8, 1);
    chk("abort_out", out8, 0);
`ifdef GCD_CYCLES_EN
    chk("abort_cycles", cyc8, 0);
`endif
    @(negedge clk);
    nrst = 1'b1;
    run_op(1'b0, 16'd240, 16'd36, res, busy);
    chk("abort_rerun_out", res, 12);
    chk("abort_rerun_busy", busy, 12);

    // 16-bit sweep
    run_op(1'b1, 16'd65535, 16'd65535, res, busy);
    chk("w16_max", res, 65535);
    run_op(1'b1, 16'd32768, 16'd49152, res, busy);
    chk("w16_pow2", res, 16384);
`ifdef GCD_CYCLES_EN
    chk("w16_pow2_cycles", cyc16, busy);
`endif
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 65535) << (i % 4));
      rb = 16'($urandom_range(0, 65535) << (i % 3));
      run_op(1'b1, ra, rb, res, busy);
      chk($sformatf("w16_rand%0d(%0d,%0d)", i, ra, rb), res, ref_gcd(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
